// File: rtl/traffic_light_timed.sv
// Two-road timed traffic light with gap-out, max-green and flashing-yellow mode.
// Moore outputs: phase is the state register, lamps decode from state and blink.
module traffic_light_timed #(
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 20,
  parameter int T_GREEN_MAX = 60,
  parameter int T_YELLOW    = 5,
  parameter int T_ALLRED    = 2,
  parameter int T_FLASH     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       TA,
  input  logic       TB,
  input  logic       flash,
  output logic       led_A_red,
  output logic       led_A_yellow,
  output logic       led_A_green,
  output logic       led_B_red,
  output logic       led_B_yellow,
  output logic       led_B_green,
  output logic [2:0] phase
);

  if (T_GREEN_MIN < 1 || T_GREEN_MAX < 1 || T_YELLOW < 1 ||
      T_ALLRED < 1 || T_FLASH < 1) begin : g_bad_t
    $fatal(1, "traffic_light_timed: all T_* must be >= 1");
  end
  if (T_GREEN_MAX < T_GREEN_MIN) begin : g_bad_max
    $fatal(1, "traffic_light_timed: T_GREEN_MAX < T_GREEN_MIN");
  end
  if (T_GREEN_MAX >= (1 << CNT_W)) begin : g_bad_w
    $fatal(1, "traffic_light_timed: T_GREEN_MAX does not fit CNT_W");
  end

  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    FLASH     = 3'd6,
    ILLEGAL   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] GMIN1 = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX1 = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL1  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR1   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] FL1   = CNT_W'(T_FLASH - 1);
  localparam logic [CNT_W-1:0] TSAT  = '1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] tmr, tmr_nx;
  logic             blink, blink_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALLRED_BA;
      tmr   <= '0;
      blink <= 1'b0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      blink <= blink_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = (tmr == TSAT) ? tmr : tmr + 1'b1;
    blink_nx = blink;
    if (flash && state != FLASH) begin
      state_nx = FLASH;
    end else begin
      case (state)
        A_GREEN:
          if (tmr >= GMIN1 && TB && (!TA || tmr >= GMAX1))
            state_nx = A_YELLOW;
        A_YELLOW:
          if (tmr == YEL1) state_nx = ALLRED_AB;
        ALLRED_AB:
          if (tmr == AR1) state_nx = B_GREEN;
        B_GREEN:
          if (tmr >= GMIN1 && TA && (!TB || tmr >= GMAX1))
            state_nx = B_YELLOW;
        B_YELLOW:
          if (tmr == YEL1) state_nx = ALLRED_BA;
        ALLRED_BA:
          if (tmr == AR1) state_nx = A_GREEN;
        FLASH:
          if (!flash) begin
            state_nx = ALLRED_BA;
          end else if (tmr == FL1) begin
            blink_nx = ~blink;
            tmr_nx   = '0;
          end
        default:
          state_nx = ALLRED_BA;
      endcase
    end
    if (state_nx != state) tmr_nx = '0;
    // Each flash episode starts with the yellows lit.
    if (state_nx == FLASH && state != FLASH) blink_nx = 1'b1;
  end

  always_comb begin
    led_A_red    = 1'b0;
    led_A_yellow = 1'b0;
    led_A_green  = 1'b0;
    led_B_red    = 1'b0;
    led_B_yellow = 1'b0;
    led_B_green  = 1'b0;
    case (state)
      A_GREEN: begin
        led_A_green = 1'b1;
        led_B_red   = 1'b1;
      end
      A_YELLOW: begin
        led_A_yellow = 1'b1;
        led_B_red    = 1'b1;
      end
      B_GREEN: begin
        led_A_red   = 1'b1;
        led_B_green = 1'b1;
      end
      B_YELLOW: begin
        led_A_red    = 1'b1;
        led_B_yellow = 1'b1;
      end
      FLASH: begin
        led_A_yellow = blink;
        led_B_yellow = blink;
      end
      default: begin
        led_A_red = 1'b1;
        led_B_red = 1'b1;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_timed.sv
// Randomized + directed bench for traffic_light_timed with a scoreboard
// fed by a behavioural road-sequence model.
module tb_traffic_light_timed;

  localparam int MIN = 4;
  localparam int MAX = 10;
  localparam int YEL = 2;
  localparam int AR  = 1;
  localparam int FL  = 3;
  localparam int SAT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       TA = 1'b0;
  logic       TB = 1'b0;
  logic       flash = 1'b0;
  logic       a_r, a_y, a_g, b_r, b_y, b_g;
  logic [2:0] phase;

  traffic_light_timed #(
    .CNT_W(8), .T_GREEN_MIN(MIN), .T_GREEN_MAX(MAX),
    .T_YELLOW(YEL), .T_ALLRED(AR), .T_FLASH(FL)
  ) dut (
    .clk(clk), .rst(rst), .TA(TA), .TB(TB), .flash(flash),
    .led_A_red(a_r), .led_A_yellow(a_y), .led_A_green(a_g),
    .led_B_red(b_r), .led_B_yellow(b_y), .led_B_green(b_g),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [5:0] lamps;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: six-step road cycle plus flash, dwell counted in cycles.
  int m_ph = 5;
  int m_t  = 0;
  bit m_bl = 0;
  bit started = 0;

  function automatic logic [5:0] lamps_of(int ph, bit bl);
    logic [2:0] a, b;
    if (ph == 0) a = 3'b001;
    else if (ph == 1) a = 3'b010;
    else if (ph == 6) a = {1'b0, bl, 1'b0};
    else a = 3'b100;
    if (ph == 3) b = 3'b001;
    else if (ph == 4) b = 3'b010;
    else if (ph == 6) b = {1'b0, bl, 1'b0};
    else b = 3'b100;
    return {a, b};
  endfunction

  task automatic model_step(input bit r, a, b, f);
    bit own, other, leave;
    if (r) begin
      m_ph = 5; m_t = 0; m_bl = 0;
    end else if (f && m_ph != 6) begin
      m_ph = 6; m_t = 0; m_bl = 1;
    end else if (m_ph == 6) begin
      if (!f) begin
        m_ph = 5; m_t = 0;
      end else if (m_t == FL - 1) begin
        m_bl = !m_bl; m_t = 0;
      end else begin
        m_t++;
      end
    end else begin
      own   = (m_ph == 0) ? a : b;
      other = (m_ph == 0) ? b : a;
      case (m_ph % 3)
        0: leave = m_t >= MIN - 1 && other && (!own || m_t >= MAX - 1);
        1: leave = (m_t == YEL - 1);
        default: leave = (m_t == AR - 1);
      endcase
      if (leave) begin
        m_ph = (m_ph + 1) % 6; m_t = 0;
      end else begin
        m_t = (m_t < SAT) ? m_t + 1 : SAT;
      end
    end
  endtask

  task automatic cyc(input bit r, a, b, f);
    exp_t e;
    if (started) @(negedge clk);
    started = 1;
    rst = r; TA = a; TB = b; flash = f;
    model_step(r, a, b, f);
    e.ph    = 3'(m_ph);
    e.lamps = lamps_of(m_ph, m_bl);
    q.push_back(e);
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  // Monitor: one output per clock, compared against the queued expectation.
  initial begin
    exp_t e;
    logic [5:0] got;
    forever begin
      @(posedge clk);
      #1;
      got = {a_r, a_y, a_g, b_r, b_y, b_g};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got ph=%0d with nothing expected",
                 phase);
      end else begin
        e = q.pop_front();
        if (phase !== e.ph || got !== e.lamps) begin
          errors++;
          $display("FAIL sb_out t=%0t: got ph=%0d lamps=%b, want ph=%0d lamps=%b",
                   $time, phase, got, e.ph, e.lamps);
        end
      end
      checks++;
      if ((a_g && b_g) || $countones({a_r, a_y, a_g}) > 1 ||
          $countones({b_r, b_y, b_g}) > 1) begin
        errors++;
        $display("FAIL lamp_excl t=%0t: got lamps=%b, want one per road, no dual green",
                 $time, got);
      end
    end
  end

  initial begin
    bit fl, r, a, b;
    // Reset then idle: A_GREEN rests, timer saturates, then demand.
    do_reset(2);
    for (int i = 0; i < 258; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0);
    // One-sided demand from B.
    do_reset(2);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 0);
    // Both roads demanding: max-green cycle.
    do_reset(2);
    for (int i = 0; i < 70; i++) cyc(0, 1, 1, 0);
    // Gap-out: A drops its demand at A_GREEN tmr=6.
    do_reset(2);
    for (int i = 0; i < 20; i++)
      cyc(0, !(m_ph == 0 && m_t >= 6), 1, 0);
    // Flash requested at A_GREEN tmr=2.
    do_reset(2);
    for (int i = 0; i < 50 && !(m_ph == 0 && m_t == 2); i++) cyc(0, 1, 1, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);
    // Reset pulsed at B_YELLOW tmr=1.
    do_reset(2);
    for (int i = 0; i < 60 && !(m_ph == 4 && m_t == 1); i++) cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);
    // Random traffic, occasional flash and reset.
    fl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) fl = !fl;
      r = ($urandom_range(0, 299) == 0);
      a = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) != 0);
      cyc(r, a, b, fl);
    end
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
